// File: rtl/data_sram_response_pkg.sv
// Shared definitions for the MEM-stage data-SRAM response path: access-type
// bit positions, default outstanding-request limit and extension helpers.
package data_sram_response_pkg;

   localparam int unsigned MAX_OUTST_DEF = 2;

   localparam int unsigned ACC_W   = 0;
   localparam int unsigned ACC_H   = 1;
   localparam int unsigned ACC_B   = 2;
   localparam int unsigned ACC_HU  = 3;
   localparam int unsigned ACC_BU  = 4;
   localparam int unsigned ACC_WL  = 5;
   localparam int unsigned ACC_WR  = 6;
   localparam int unsigned ACC_NUM = 7;

   typedef logic [ACC_NUM-1:0] acc_type_t;

   function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
      return {{24{sgn & v[7]}}, v};
   endfunction

   function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
      return {{16{sgn & v[15]}}, v};
   endfunction

endpackage

// File: rtl/data_sram_response_load_data_extract.sv
// Combinational load-data extraction: selects/extends bytes and halves and
// performs the lwl/lwr merge with the old rt value.
module load_data_extract
   import data_sram_response_pkg::*;
(
   input  logic [31:0] rdata,
   input  acc_type_t   acc_type,
   input  logic [1:0]  byte_offset,
   input  logic [31:0] rt_old,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (byte_offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = byte_offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      load_data = '0;
      if (acc_type[ACC_W]) begin
         load_data = rdata;
      end else if (acc_type[ACC_B] | acc_type[ACC_BU]) begin
         load_data = ext8(byte_sel, acc_type[ACC_B]);
      end else if (acc_type[ACC_H] | acc_type[ACC_HU]) begin
         load_data = ext16(half_sel, acc_type[ACC_H]);
      end else if (acc_type[ACC_WL]) begin
         // lwl fills the high end of rt with the low bytes of the word
         case (byte_offset)
            2'd0:    load_data = {rdata[7:0],  rt_old[23:0]};
            2'd1:    load_data = {rdata[15:0], rt_old[15:0]};
            2'd2:    load_data = {rdata[23:0], rt_old[7:0]};
            default: load_data = rdata;
         endcase
      end else if (acc_type[ACC_WR]) begin
         case (byte_offset)
            2'd0:    load_data = rdata;
            2'd1:    load_data = {rt_old[31:24], rdata[31:8]};
            2'd2:    load_data = {rt_old[31:16], rdata[31:16]};
            default: load_data = {rt_old[31:8],  rdata[31:24]};
         endcase
      end
   end

endmodule

// File: rtl/data_sram_response.sv
// MEM-stage data-SRAM response tracker: counts outstanding requests, drops
// beats of flushed instructions, buffers early beats and extracts load data.
module data_sram_response
   import data_sram_response_pkg::*;
#(
   parameter int unsigned MAX_OUTST = MAX_OUTST_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_accepted_EX,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   output logic        req_allow_EX,
   input  logic        mem_req_MEM,
   input  logic        MEM_WB_transfer,
   input  logic        flush,
   input  logic        mem_w_MEM,
   input  logic        mem_h_MEM,
   input  logic        mem_b_MEM,
   input  logic        mem_hu_MEM,
   input  logic        mem_bu_MEM,
   input  logic        mem_wl_MEM,
   input  logic        mem_wr_MEM,
   input  logic [1:0]  byte_offset_MEM,
   input  logic [31:0] rt_old_MEM,
   output logic [31:0] load_data_MEM,
   output logic        data_ready_MEM,
   output logic        MEM_stall_not_ready
);

   localparam int unsigned CW = $clog2(MAX_OUTST + 1);

   logic [CW-1:0] outst_cnt;
   logic [CW-1:0] discard_cnt;
   logic          buf_valid;
   logic [31:0]   buf_data;
   logic          live_ok;
   logic [31:0]   src_data;
   logic [31:0]   ext_data;
   acc_type_t     acc_type;

   always_comb begin
      acc_type         = '0;
      acc_type[ACC_W]  = mem_w_MEM;
      acc_type[ACC_H]  = mem_h_MEM;
      acc_type[ACC_B]  = mem_b_MEM;
      acc_type[ACC_HU] = mem_hu_MEM;
      acc_type[ACC_BU] = mem_bu_MEM;
      acc_type[ACC_WL] = mem_wl_MEM;
      acc_type[ACC_WR] = mem_wr_MEM;
   end

   assign live_ok             = data_sram_data_ok & (discard_cnt == '0);
   assign req_allow_EX        = (outst_cnt < CW'(MAX_OUTST));
   assign data_ready_MEM      = buf_valid | (live_ok & mem_req_MEM);
   assign MEM_stall_not_ready = mem_req_MEM & ~data_ready_MEM;
   assign src_data            = buf_valid ? buf_data : data_sram_rdata;
   assign load_data_MEM       = data_ready_MEM ? ext_data : '0;

   load_data_extract u_extract (
      .rdata       (src_data),
      .acc_type    (acc_type),
      .byte_offset (byte_offset_MEM),
      .rt_old      (rt_old_MEM),
      .load_data   (ext_data)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         outst_cnt <= '0;
      end else begin
         case ({req_accepted_EX, data_sram_data_ok})
            2'b10:   outst_cnt <= outst_cnt + CW'(1);
            2'b01:   outst_cnt <= outst_cnt - CW'(1);
            default: outst_cnt <= outst_cnt;
         endcase
      end
   end

   // A beat arriving in the flush cycle is already consumed, so it is not
   // left in the discard count.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         discard_cnt <= '0;
      end else if (flush) begin
         discard_cnt <= outst_cnt - CW'(data_sram_data_ok);
      end else if (data_sram_data_ok && discard_cnt != '0) begin
         discard_cnt <= discard_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         buf_valid <= 1'b0;
         buf_data  <= '0;
      end else if (flush || MEM_WB_transfer) begin
         buf_valid <= 1'b0;
      end else if (live_ok && mem_req_MEM) begin
         buf_valid <= 1'b1;
         buf_data  <= data_sram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         assert (!(data_sram_data_ok && outst_cnt == '0));
         assert (!(live_ok && buf_valid));
      end
   end

endmodule
